sram_arbiter: RTL

Arbitrates a single-port, one-cycle-latency SRAM between two requesters: instruction fetch (read-only) and data memory access (read/write). It sits between the pipeline stages and the unified SRAM. Per requester it provides a request/address-accept handshake and a response handshake with a one-entry response buffer. Data accesses have fixed priority over fetch, with a starvation counter that guarantees fetch progress.

---
 rtl/sram_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Shares one single-port, one-cycle-latency SRAM between instruction fetch and data access.
// Data has fixed priority; a starvation counter hands priority to fetch after STARVE_LIMIT denials.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_rready,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  input  logic        data_rready,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  logic        inst_inflight_q, inst_inflight_d;
  logic        data_inflight_q, data_inflight_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic        data_buf_valid_q, data_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] data_buf_q, data_buf_d;
  logic [3:0]  starve_q, starve_d;

  logic inst_elig, data_elig, starved;
  logic grant_inst, grant_data;

  // A port is eligible only if its response slot is guaranteed free next cycle.
  always_comb begin
    inst_elig  = inst_req && !inst_buf_valid_q && !(inst_inflight_q && !inst_rready);
    data_elig  = data_req && !data_buf_valid_q && !(data_inflight_q && !data_rready);
    starved    = (starve_q >= 4'(STARVE_LIMIT));
    grant_data = !reset && data_elig && !(inst_elig && starved);
    grant_inst = !reset && inst_elig && !grant_data;
  end

  always_comb begin
    inst_inflight_d  = grant_inst;
    data_inflight_d  = grant_data;

    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    if (inst_inflight_q && !inst_rready) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = sram_rdata;
    end else if (inst_buf_valid_q && inst_rready) begin
      inst_buf_valid_d = 1'b0;
    end

    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;
    if (data_inflight_q && !data_rready) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = sram_rdata;
    end else if (data_buf_valid_q && data_rready) begin
      data_buf_valid_d = 1'b0;
    end

    starve_d = starve_q;
    if (!inst_req || grant_inst) begin
      starve_d = '0;
    end else if (inst_elig && starve_q != 4'hf) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_inflight_q  <= 1'b0;
      data_inflight_q  <= 1'b0;
      inst_buf_valid_q <= 1'b0;
      data_buf_valid_q <= 1'b0;
      inst_buf_q       <= '0;
      data_buf_q       <= '0;
      starve_q         <= '0;
    end else begin
      inst_inflight_q  <= inst_inflight_d;
      data_inflight_q  <= data_inflight_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      data_buf_valid_q <= data_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      data_buf_q       <= data_buf_d;
      starve_q         <= starve_d;
    end
  end

  // Read data is forced to zero whenever no response is being presented.
  always_comb begin
    inst_addr_ok = grant_inst;
    data_addr_ok = grant_data;
    inst_data_ok = inst_buf_valid_q || inst_inflight_q;
    data_data_ok = data_buf_valid_q || data_inflight_q;
    inst_rdata   = inst_buf_valid_q ? inst_buf_q : (inst_inflight_q ? sram_rdata : '0);
    data_rdata   = data_buf_valid_q ? data_buf_q : (data_inflight_q ? sram_rdata : '0);

    sram_en    = grant_inst || grant_data;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      sram_wen   = data_wr ? data_wstrb : 4'h0;
    end else if (grant_inst) begin
      sram_addr  = inst_addr;
    end
  end

endmodule
